// File: rtl/nvp_pe_controller.sv
// Processing-element controller: MAC accumulate, 8.8 quantize with saturation, optional ReLU.
// Define NVP_PE_MAX_POOLING_EN to build the max-pooling stage (cfg_pooling/cfg_pool_count).
module nvp_pe_controller #(
  parameter int DATA_WIDTH        = 16,
  parameter int WEIGHT_WIDTH      = 16,
  parameter int UNQUANTIZED_WIDTH = 48,
  parameter int HALF_DATA_WIDTH   = 8
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [15:0]             cfg_kernel_len,
  input  logic [15:0]             cfg_num_outputs,
  input  logic                    cfg_activation,
  input  logic                    cfg_pooling,
  input  logic [3:0]              cfg_pool_count,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic [WEIGHT_WIDTH-1:0] in_weight,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    busy
);
  localparam int PROD_WIDTH = DATA_WIDTH + WEIGHT_WIDTH;
  localparam int QW         = UNQUANTIZED_WIDTH - HALF_DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, ACCUM, QUANT, OUT} state_t;
  state_t state_q, state_d;

  logic [15:0]                  kernel_last_q, outputs_last_q, mac_cnt_q, out_cnt_q;
  logic                         relu_q;
  logic [UNQUANTIZED_WIDTH-1:0] acc_q;
  logic [DATA_WIDTH-1:0]        out_data_q;

  logic                         beat, mac_last, out_hs, out_last, pool_continue;
  logic signed [PROD_WIDTH-1:0] product;
  logic [UNQUANTIZED_WIDTH-1:0] product_ext;
  logic [QW-1:0]                q_full;
  logic [DATA_WIDTH-1:0]        q_sat, act_val, result;
  logic                         unused_frac;

  assign cfg_ready = (state_q == IDLE);
  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == OUT);
  assign busy      = (state_q != IDLE);
  assign out_data  = out_data_q;

  assign beat     = in_valid && in_ready;
  assign mac_last = (mac_cnt_q == kernel_last_q);
  assign out_hs   = out_valid && out_ready;
  assign out_last = (out_cnt_q == outputs_last_q);

  assign product     = $signed(in_data) * $signed(in_weight);
  assign product_ext = {{(UNQUANTIZED_WIDTH-PROD_WIDTH){product[PROD_WIDTH-1]}}, product};

  // Fits in DATA_WIDTH only when all bits above the result sign agree with it
  assign q_full      = acc_q[UNQUANTIZED_WIDTH-1:HALF_DATA_WIDTH];
  assign unused_frac = ^acc_q[HALF_DATA_WIDTH-1:0];
  always_comb begin
    q_sat = q_full[DATA_WIDTH-1:0];
    if (q_full[QW-1:DATA_WIDTH-1] != '0 && q_full[QW-1:DATA_WIDTH-1] != '1)
      q_sat = q_full[QW-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
  end
  assign act_val = (relu_q && q_sat[DATA_WIDTH-1]) ? '0 : q_sat;

`ifdef NVP_PE_MAX_POOLING_EN
  logic                  pool_en_q;
  logic [3:0]            pool_last_q, pool_cnt_q;
  logic [DATA_WIDTH-1:0] pool_max_q, pool_next;

  assign pool_next     = (pool_cnt_q == 4'd0 || $signed(act_val) > $signed(pool_max_q)) ? act_val : pool_max_q;
  assign pool_continue = pool_en_q && (pool_cnt_q != pool_last_q);
  assign result        = pool_en_q ? pool_next : act_val;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pool_en_q   <= 1'b0;
      pool_last_q <= '0;
      pool_cnt_q  <= '0;
      pool_max_q  <= '0;
    end else begin
      if (state_q == IDLE && cfg_valid) begin
        pool_en_q   <= cfg_pooling;
        pool_last_q <= (cfg_pool_count == '0) ? '0 : cfg_pool_count - 4'd1;
        pool_cnt_q  <= '0;
      end else if (state_q == QUANT && pool_en_q) begin
        pool_max_q <= pool_next;
        pool_cnt_q <= pool_cnt_q + 4'd1;
      end else if (out_hs) begin
        pool_cnt_q <= '0;
      end
    end
  end
`else
  logic unused_pool_cfg;
  assign unused_pool_cfg = cfg_pooling ^ (^cfg_pool_count);
  assign pool_continue   = 1'b0;
  assign result          = act_val;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cfg_valid) state_d = ACCUM;
      ACCUM:   if (beat && mac_last) state_d = QUANT;
      QUANT:   state_d = pool_continue ? ACCUM : OUT;
      OUT:     if (out_hs) state_d = out_last ? IDLE : ACCUM;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      kernel_last_q  <= '0;
      outputs_last_q <= '0;
      mac_cnt_q      <= '0;
      out_cnt_q      <= '0;
      relu_q         <= 1'b0;
      acc_q          <= '0;
      out_data_q     <= '0;
    end else begin
      case (state_q)
        IDLE: if (cfg_valid) begin
          kernel_last_q  <= (cfg_kernel_len == '0) ? '0 : cfg_kernel_len - 16'd1;
          outputs_last_q <= (cfg_num_outputs == '0) ? '0 : cfg_num_outputs - 16'd1;
          relu_q         <= cfg_activation;
          acc_q          <= '0;
          mac_cnt_q      <= '0;
          out_cnt_q      <= '0;
        end
        ACCUM: if (beat) begin
          acc_q     <= acc_q + product_ext;
          mac_cnt_q <= mac_cnt_q + 16'd1;
        end
        QUANT: begin
          if (pool_continue) begin
            acc_q     <= '0;
            mac_cnt_q <= '0;
          end else begin
            out_data_q <= result;
          end
        end
        OUT: if (out_ready) begin
          out_cnt_q <= out_cnt_q + 16'd1;
          acc_q     <= '0;
          mac_cnt_q <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nvp_pe_controller.sv
// Self-checking bench for nvp_pe_controller: directed vectors plus randomized jobs
// checked against an arithmetic reference model.
`timescale 1ns/1ps
module tb_nvp_pe_controller;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [15:0] cfg_kernel_len = '0;
  logic [15:0] cfg_num_outputs = '0;
  logic        cfg_activation = 1'b0;
  logic        cfg_pooling = 1'b0;
  logic [3:0]  cfg_pool_count = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic [15:0] in_weight = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic        busy;

`ifdef NVP_PE_MAX_POOLING_EN
  localparam bit POOL_BUILT = 1'b1;
`else
  localparam bit POOL_BUILT = 1'b0;
`endif

  int errors = 0;
  int checks = 0;
  logic [15:0] stim_d[$];
  logic [15:0] stim_w[$];
  logic [15:0] exp_q[$];
  int          last_beat_cyc[$];

  always #5 clk = ~clk;

  nvp_pe_controller #(
    .DATA_WIDTH(16), .WEIGHT_WIDTH(16), .UNQUANTIZED_WIDTH(48), .HALF_DATA_WIDTH(8)
  ) dut (
    .clk(clk), .resetn(resetn),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_kernel_len(cfg_kernel_len), .cfg_num_outputs(cfg_num_outputs),
    .cfg_activation(cfg_activation), .cfg_pooling(cfg_pooling), .cfg_pool_count(cfg_pool_count),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_weight(in_weight),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  // Reference: exact sum, wrap to 48 bits, floor-divide by 256, clamp, optional ReLU
  function automatic logic [15:0] model_output(longint acc, bit relu);
    longint q;
    acc = (acc <<< 16) >>> 16;
    q = acc >>> 8;
    if (q > 32767) q = 32767;
    else if (q < -32768) q = -32768;
    if (relu && q < 0) q = 0;
    return q[15:0];
  endfunction

  function automatic int pool_eff(bit pool, int pcnt);
    return (POOL_BUILT && pool) ? ((pcnt == 0) ? 1 : pcnt) : 1;
  endfunction

  function automatic void build_expected(int klen, int nout, bit relu, bit pool, int pcnt);
    int k = (klen == 0) ? 1 : klen;
    int no = (nout == 0) ? 1 : nout;
    int pe = pool_eff(pool, pcnt);
    int b = 0;
    longint acc;
    logic [15:0] v;
    logic [15:0] best;
    best = '0;
    exp_q.delete();
    for (int o = 0; o < no; o++) begin
      for (int p = 0; p < pe; p++) begin
        acc = 0;
        for (int i = 0; i < k; i++) begin
          acc += longint'($signed(stim_d[b])) * longint'($signed(stim_w[b]));
          b++;
        end
        v = model_output(acc, relu);
        if (p == 0 || $signed(v) > $signed(best)) best = v;
      end
      exp_q.push_back(best);
    end
  endfunction

  function automatic logic [15:0] rand_word();
    logic [15:0] r = 16'($urandom);
    case ($urandom_range(0, 3))
      0:       return r;
      1:       return {{6{r[9]}}, r[9:0]};
      2:       return r[0] ? 16'h7FFF : 16'h8000;
      default: return {{8{r[7]}}, r[7:0]};
    endcase
  endfunction

  task automatic clear_stim();
    stim_d.delete();
    stim_w.delete();
    exp_q.delete();
  endtask

  task automatic add_beat(input logic [15:0] d, input logic [15:0] w);
    stim_d.push_back(d);
    stim_w.push_back(w);
  endtask

  task automatic run_job(input string name, input int klen, input int nout, input bit relu,
                         input bit pool, input int pcnt, input bit rnd, input int stall);
    int n = stim_d.size();
    int nexp = exp_q.size();
    int span = ((klen == 0) ? 1 : klen) * pool_eff(pool, pcnt);
    int idx = 0;
    int got = 0;
    int cyc = 0;
    int lat;
    int stall_left = stall;
    bit prev_ov = 1'b0;
    last_beat_cyc.delete();
    @(negedge clk);
    checks++;
    if (cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s cfg_ready_at_start: got %b expected 1", name, cfg_ready);
    end
    cfg_valid = 1'b1;
    cfg_kernel_len = klen[15:0];
    cfg_num_outputs = nout[15:0];
    cfg_activation = relu;
    cfg_pooling = pool;
    cfg_pool_count = pcnt[3:0];
    @(negedge clk);
    while (got < nexp && cyc < 4000) begin
      // Configuration offered mid-job must be ignored
      cfg_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      cfg_kernel_len = 16'($urandom);
      cfg_num_outputs = 16'($urandom);
      cfg_activation = 1'($urandom);
      cfg_pooling = 1'($urandom);
      cfg_pool_count = 4'($urandom);
      in_valid = (idx < n) && (!rnd || $urandom_range(0, 3) != 0);
      in_data = (idx < n) ? stim_d[idx] : 16'($urandom);
      in_weight = (idx < n) ? stim_w[idx] : 16'($urandom);
      if (out_valid && stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else begin
        out_ready = !rnd || ($urandom_range(0, 2) != 0);
      end
      if (out_valid && !prev_ov) begin
        lat = (last_beat_cyc.size() == 0) ? -1 : cyc - last_beat_cyc[0];
        checks++;
        if (lat != 2) begin
          errors++;
          $display("FAIL %s latency: got %0d edges expected 2", name, lat);
        end
        if (last_beat_cyc.size() != 0) void'(last_beat_cyc.pop_front());
      end
      if (out_valid) begin
        checks++;
        if (got >= nexp) begin
          errors++;
          $display("FAIL %s spurious_output: got %h with no result expected", name, out_data);
        end else if (out_data !== exp_q[got]) begin
          errors++;
          $display("FAIL %s out_data[%0d]: got %h expected %h", name, got, out_data, exp_q[got]);
        end
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL %s in_ready_during_out: got %b expected 0", name, in_ready);
        end
      end
      if (in_valid && in_ready) begin
        if ((idx + 1) % span == 0) last_beat_cyc.push_back(cyc);
        idx++;
      end
      if (out_valid && out_ready) got++;
      prev_ov = out_valid;
      @(negedge clk);
      cyc++;
    end
    cfg_valid = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (cyc >= 4000) begin
      errors++;
      $display("FAIL %s timeout: got %0d outputs expected %0d", name, got, nexp);
    end
    checks++;
    if (idx != n) begin
      errors++;
      $display("FAIL %s beats_consumed: got %0d expected %0d", name, idx, n);
    end
    checks++;
    if (busy !== 1'b0 || cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s idle_after_job: got busy=%b cfg_ready=%b expected busy=0 cfg_ready=1", name, busy, cfg_ready);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (cfg_ready !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 16'h0000) begin
      errors++;
      $display("FAIL %s: got cfg_ready=%b busy=%b in_ready=%b out_valid=%b out_data=%h expected 1 0 0 0 0000",
               name, cfg_ready, busy, in_ready, out_valid, out_data);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    #12;
    check_reset_outputs("reset_state");
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check_reset_outputs("idle_after_release");
  endtask

  task automatic test_basic();
    clear_stim();
    add_beat(16'h0100, 16'h0100);
    add_beat(16'h0100, 16'h0200);
    add_beat(16'h0100, 16'h0300);
    exp_q.push_back(16'h0600);
    run_job("basic", 3, 1, 1'b0, 1'b0, 0, 1'b0, 0);
  endtask

  task automatic test_saturation();
    clear_stim();
    repeat (4) add_beat(16'h7FFF, 16'h7FFF);
    exp_q.push_back(16'h7FFF);
    run_job("sat_pos", 4, 1, 1'b0, 1'b0, 0, 1'b0, 0);
    clear_stim();
    repeat (4) add_beat(16'h8000, 16'h7FFF);
    exp_q.push_back(16'h8000);
    run_job("sat_neg", 4, 1, 1'b0, 1'b0, 0, 1'b0, 0);
    clear_stim();
    repeat (4) add_beat(16'h8000, 16'h7FFF);
    exp_q.push_back(16'h0000);
    run_job("sat_neg_relu", 4, 1, 1'b1, 1'b0, 0, 1'b0, 0);
  endtask

  task automatic test_relu();
    clear_stim();
    add_beat(16'hFF00, 16'h0100);
    exp_q.push_back(16'hFF00);
    run_job("neg_no_act", 1, 1, 1'b0, 1'b0, 0, 1'b0, 0);
    clear_stim();
    add_beat(16'hFF00, 16'h0100);
    exp_q.push_back(16'h0000);
    run_job("neg_relu", 1, 1, 1'b1, 1'b0, 0, 1'b0, 0);
  endtask

  task automatic test_pooling();
    clear_stim();
    add_beat(16'h0080, 16'h0100);
    add_beat(16'hFF00, 16'h0100);
    add_beat(16'h0300, 16'h0100);
`ifdef NVP_PE_MAX_POOLING_EN
    exp_q.push_back(16'h0300);
    run_job("pool_max", 1, 1, 1'b0, 1'b1, 3, 1'b0, 0);
`else
    exp_q.push_back(16'h0080);
    exp_q.push_back(16'hFF00);
    exp_q.push_back(16'h0300);
    run_job("pool_ignored", 1, 3, 1'b0, 1'b1, 3, 1'b0, 0);
`endif
  endtask

  task automatic test_back_to_back_backpressure();
    clear_stim();
    add_beat(16'h0200, 16'h0100);
    add_beat(16'h0100, 16'h0100);
    add_beat(16'hFF00, 16'h0200);
    add_beat(16'h0000, 16'h0100);
    exp_q.push_back(16'h0300);
    exp_q.push_back(16'hFE00);
    run_job("backpressure", 2, 2, 1'b0, 1'b0, 0, 1'b0, 5);
  endtask

  task automatic test_reset_mid_job();
    bit seen_ov = 1'b0;
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_kernel_len = 16'd8;
    cfg_num_outputs = 16'd1;
    cfg_activation = 1'b0;
    cfg_pooling = 1'b0;
    cfg_pool_count = 4'd0;
    @(negedge clk);
    cfg_valid = 1'b0;
    in_valid = 1'b1;
    in_data = 16'h0100;
    in_weight = 16'h0100;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    #2 resetn = 1'b0;
    #1;
    check_reset_outputs("reset_mid_accum");
    @(negedge clk);
    resetn = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen_ov = 1'b1;
    end
    checks++;
    if (seen_ov || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_discards_job: got out_valid_seen=%b busy=%b expected 0 0", seen_ov, busy);
    end
    out_ready = 1'b0;
    clear_stim();
    add_beat(16'h0100, 16'h0100);
    add_beat(16'h0100, 16'h0200);
    add_beat(16'h0100, 16'h0300);
    exp_q.push_back(16'h0600);
    run_job("job_after_reset", 3, 1, 1'b0, 1'b0, 0, 1'b0, 0);
  endtask

  task automatic test_random();
    int klen;
    int nout;
    int pcnt;
    int n;
    bit relu;
    bit pool;
    for (int j = 0; j < 10; j++) begin
      klen = $urandom_range(0, 5);
      nout = $urandom_range(0, 3);
      pcnt = $urandom_range(0, 3);
      relu = 1'($urandom);
      pool = 1'($urandom);
      n = ((klen == 0) ? 1 : klen) * ((nout == 0) ? 1 : nout) * pool_eff(pool, pcnt);
      clear_stim();
      for (int i = 0; i < n; i++) add_beat(rand_word(), rand_word());
      build_expected(klen, nout, relu, pool, pcnt);
      run_job($sformatf("random%0d", j), klen, nout, relu, pool, pcnt, 1'b1, $urandom_range(0, 3));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached with %0d errors of %0d checks", errors, checks);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_relu();
    test_pooling();
    test_back_to_back_backpressure();
    test_reset_mid_job();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nvp_pe_controller.md
NVP_PE_CONTROLLER -- requirements
Module: nvp_pe_controller

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  DATA_WIDTH, 16, activation/output width, signed 8.8 fixed point
  WEIGHT_WIDTH, 16, weight width, signed 8.8 fixed point
  UNQUANTIZED_WIDTH, 48, accumulator width, signed 32.16
  HALF_DATA_WIDTH, 8, fractional bits dropped at quantization
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk  in  1  single clock, rising edge
  resetn  in  1  asynchronous, active-low reset
  cfg_valid  in  1  job configuration offered
  cfg_ready  out  1  controller idle, accepts configuration
  cfg_kernel_len  in  16  products per output (0 treated as 1)
  cfg_num_outputs  in  16  outputs per job (0 treated as 1)
  cfg_activation  in  1  0 = NO_ACTIVATION, 1 = RELU
  cfg_pooling  in  1  0 = NO_POOLING, 1 = MAX_POOLING
  cfg_pool_count  in  4  activated values pooled per output (0 treated as 1)
  in_valid  in  1  operand pair offered
  in_ready  out  1  operand pair accepted
  in_data  in  DATA_WIDTH  signed data operand
  in_weight  in  WEIGHT_WIDTH  signed weight operand
  out_valid  out  1  result available
  out_ready  in  1  downstream accepts result
  out_data  out  DATA_WIDTH  quantized, activated, pooled result
  busy  out  1  high whenever state is not IDLE

Function
REQ-003 FSM states SHALL be IDLE, ACCUM, QUANT, OUT; all outputs registered or decoded from state only.
REQ-004 IDLE: cfg_ready=1; on cfg_valid the config SHALL be latched, acc, mac_cnt, pool_cnt and out_cnt cleared, next state ACCUM.
REQ-005 ACCUM: in_ready=1; each in_valid&in_ready beat SHALL add sign-extended in_data*in_weight (32-bit signed product) to acc and increment mac_cnt.
REQ-006 The beat with mac_cnt == kernel_len-1 SHALL move to QUANT; no further beats accepted until ACCUM re-entered.
REQ-007 QUANT (one cycle): q = acc[47:8] saturated to [-32768, 32767]; a = (RELU and q<0) ? 0 : q.
REQ-008 QUANT with pooling active: pool_max = (pool_cnt==0) ? a : signed max(pool_max, a); pool_cnt++; if pool_cnt == pool_count-1 go OUT with out_data=pool_max result, else clear acc and mac_cnt, return to ACCUM.
REQ-009 QUANT without pooling active SHALL load out_data=a and go OUT.
REQ-010 OUT: out_valid=1, out_data stable, in_ready=0 until out_ready; on handshake out_cnt++, pool_cnt and acc cleared; if out_cnt == num_outputs-1 go IDLE else ACCUM.
REQ-011 Latency: out_valid SHALL rise on the 2nd rising clk edge after the final input beat of an output.
REQ-012 cfg_valid outside IDLE SHALL be ignored; config changes take effect only at next job.
REQ-013 Accumulator overflow beyond 48 bits SHALL wrap (two's complement); only quantization saturates.

Reset
REQ-014 resetn low SHALL asynchronously force IDLE, acc=0, all counters 0, pool_max=0, out_data=0, out_valid=0, in_ready=0, busy=0, cfg_ready=1.
REQ-015 Reset mid-job SHALL discard the job; no partial result emitted after release.

Configuration
REQ-016 Macro NVP_PE_MAX_POOLING_EN defined: max pooling per REQ-008 when cfg_pooling=1.
REQ-017 Macro undefined: cfg_pooling and cfg_pool_count ignored, pooling logic absent, every activated value emitted per REQ-009.

Verification
REQ-018 kernel_len=3, data 0x0100, weights 0x0100/0x0200/0x0300, no act/pool -> one output 0x0600, out_valid 2 edges after last beat, then IDLE.
REQ-019 kernel_len=4, data=weight=0x7FFF -> 0x7FFF; data 0x8000 weight 0x7FFF -> 0x8000 (NO_ACTIVATION), 0x0000 (RELU).
REQ-020 kernel_len=1, data 0xFF00, weight 0x0100 -> 0xFF00 without activation, 0x0000 with RELU.
REQ-021 Macro on, pool_count=3, kernel_len=1, weight 0x0100, data 0x0080/0xFF00/0x0300 -> single output 0x0300; macro off -> outputs 0x0080, 0xFF00, 0x0300.
REQ-022 out_ready held low 5 cycles in OUT -> out_valid=1, out_data stable, in_ready=0 throughout; num_outputs=2 continues after handshake.
REQ-023 resetn pulsed low mid-ACCUM -> immediate IDLE, out_valid=0, cfg_ready=1; next job produces correct result.
